z3_slave_sequencer: RTL
=======================

Name: z3_slave_sequencer

Overview:
- Parametrised Zorro III slave cycle sequencer for the A4092 card logic. Replaces the fixed four-state slave FSM and its hard-wired OR of per-target acknowledges.
- Claims a bus cycle, latches exactly one of NUM_TARGETS one-hot decoded regions (ROM, SCSI, INTREG, IDREG, ...) and waits for that target's acknowledge only.
- Drives DTACK and SLAVE_n. Adds a cycle watchdog with abort/timeout reporting.
- Sits between the address latch/decoder and the per-region access engines.

Parameters:
- NUM_TARGETS, 4, number of decoded target regions; width of the select/ack vectors, minimum 1.
- TIMEOUT_CYCLES, 255, CLK cycles allowed in START+DATA before forced termination; 0 disables the watchdog.
- CNT_W, 8, watchdog counter width; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- CLK  input  1  card clock (25 MHz)
- RESET  input  1  synchronous, active-high reset
- FCS_n  input  1  buffered Zorro full-cycle strobe, active low
- ADDR_MATCH  input  1  base address matched, latched at FCS_n falling edge
- FC  input  3  Zorro function codes
- DS_n  input  4  Zorro data strobes, asynchronous
- DOE  input  1  Zorro data output enable, asynchronous
- REGION_SEL  input  NUM_TARGETS  one-hot region decode, valid while FCS_n low
- TGT_DTACK  input  NUM_TARGETS  per-target ready, active high
- TGT_CYCLE  output  NUM_TARGETS  latched selected target, one-hot
- SLAVE_n  output  1  Zorro SLAVE_n
- DTACK_OE  output  1  pull DTACK_n low when 1
- BERR_OE  output  1  pull BERR_n low when 1; tied 0 unless the optional feature is enabled
- BUSY  output  1  state != IDLE
- TIMEOUT_ERR  output  1  one-cycle pulse on watchdog expiry
- ABORT  output  1  one-cycle pulse when FCS_n rises before END

Behaviour:
- validspace = FC[1] ^ FC[0].
- claim = !FCS_n && ADDR_MATCH && validspace && |REGION_SEL.
- Reset values: state IDLE; TGT_CYCLE 0; DTACK_OE 0; BERR_OE 0; TIMEOUT_ERR 0; ABORT 0; BUSY 0; counter 0; synchroniser flops 0. SLAVE_n is 1 while RESET is high.
- Synchronisers: ds_active = (DS_n != 4'hF) and DOE each pass through 2 flops; ds_s and doe_s are the second-stage outputs.
- State encoding: Z3_IDLE, Z3_START, Z3_DATA, Z3_END.
- IDLE:
  - DTACK_OE <= 0.
  - If claim: go to START next edge.
  - TGT_CYCLE <= lowest-index set bit of REGION_SEL (priority encode; multiple bits set is legal).
  - Counter <= 0.
- START:
  - FCS_n high -> IDLE, ABORT pulse, TGT_CYCLE <= 0.
  - Else if doe_s && ds_s -> DATA.
- DATA:
  - FCS_n high -> IDLE, ABORT pulse.
  - Else if |(TGT_DTACK & TGT_CYCLE) -> END. Acks from non-selected targets are ignored.
- END:
  - While FCS_n low: DTACK_OE <= 1, so DTACK asserts one CLK after entering END.
  - FCS_n high -> IDLE; DTACK_OE and TGT_CYCLE <= 0 on the same edge.
- Watchdog:
  - Counter increments every cycle in START or DATA and saturates.
  - When counter == TIMEOUT_CYCLES-1 and no exit condition is present: go to END and pulse TIMEOUT_ERR.
  - FCS_n high takes precedence over timeout (ABORT only). Target ack in the same cycle as expiry -> normal END, no TIMEOUT_ERR.
- SLAVE_n = !(claim || (BUSY && !FCS_n)). Combinational for Zorro response time; high in IDLE with no claim.
- Minimum cycle: claim edge to DTACK_OE = 1 (START) + 2 (sync) + 1 (DATA ack) + 1 (END) = 5 CLK with an immediate target ack.
- RESET mid-cycle forces the reset values at the next edge, regardless of FCS_n.

Optional Feature:
- Macro Z3_TIMEOUT_BERR_EN.
- Defined: on watchdog expiry enter END with BERR_OE <= 1 instead of DTACK_OE. BERR_OE clears when FCS_n rises.
- Undefined: expiry terminates with DTACK_OE (graceful, data undefined) and BERR_OE is constant 0.
- TIMEOUT_ERR pulses in both builds.

Decomposition:
- Package z3_pkg holds: the 2-bit state localparams Z3_IDLE=0, Z3_START=1, Z3_DATA=2, Z3_END=3; a validspace function; and a lowest-set-bit priority function, shared with the DMA master.
- One sub-module, sync2: a 2-flop synchroniser with synchronous active-high reset, instantiated for ds_active and DOE.

Test Plan:
- NUM_TARGETS=4, REGION_SEL=4'b0100, FC=3'b001, DS/DOE asserted, TGT_DTACK[2] rises 2 cycles into DATA -> TGT_CYCLE=4'b0100, DTACK_OE high until FCS_n rises, then 0 on the next edge.
- REGION_SEL=4'b0110, TGT_DTACK=4'b0100 held -> TGT_CYCLE=4'b0010, stays in DATA; DTACK only after TGT_DTACK[1] asserts.
- FC=3'b011 (invalid space) or REGION_SEL=0 with ADDR_MATCH=1 -> SLAVE_n stays 1, BUSY stays 0.
- TIMEOUT_CYCLES=16, target never acks -> TIMEOUT_ERR pulses exactly 16 cycles after START entry; DTACK_OE=1 (BERR_OE=1 with Z3_TIMEOUT_BERR_EN).
- FCS_n rises in DATA before ack -> ABORT one-cycle pulse, IDLE next edge, DTACK_OE never asserted.
- RESET asserted in END with FCS_n low -> all outputs at reset values next edge; SLAVE_n=1.

Source files
------------

// File: rtl/z3_pkg.sv
// Shared Zorro III definitions: cycle-sequencer state encoding plus address-space
// and priority helpers used by both the slave sequencer and the DMA master.
package z3_pkg;

  typedef enum logic [1:0] {
    Z3_IDLE  = 2'd0,
    Z3_START = 2'd1,
    Z3_DATA  = 2'd2,
    Z3_END   = 2'd3
  } z3_state_e;

  // Widest select vector the priority helper handles.
  localparam int Z3_SEL_MAX = 32;

  // Data and program spaces (FC = x01 / x10) are the only ones the card answers.
  function automatic logic validspace(input logic [2:0] fc);
    return fc[1] ^ fc[0];
  endfunction

  // Isolates the lowest-index set bit; zero in, zero out.
  function automatic logic [Z3_SEL_MAX-1:0] lowest_set(input logic [Z3_SEL_MAX-1:0] v);
    return v & (-v);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for the asynchronous Zorro strobes, synchronous active-high reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make both flops sample together, so d takes two edges to reach q.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/z3_slave_sequencer.sv
// Zorro III slave cycle sequencer: claims a cycle, waits for the selected target's ack, drives DTACK/SLAVE_n.
// Build option Z3_TIMEOUT_BERR_EN: watchdog expiry terminates with BERR instead of DTACK.
module z3_slave_sequencer
  import z3_pkg::*;
#(
  parameter int NUM_TARGETS    = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   FCS_n,
  input  logic                   ADDR_MATCH,
  input  logic [2:0]             FC,
  input  logic [3:0]             DS_n,
  input  logic                   DOE,
  input  logic [NUM_TARGETS-1:0] REGION_SEL,
  input  logic [NUM_TARGETS-1:0] TGT_DTACK,
  output logic [NUM_TARGETS-1:0] TGT_CYCLE,
  output logic                   SLAVE_n,
  output logic                   DTACK_OE,
  output logic                   BERR_OE,
  output logic                   BUSY,
  output logic                   TIMEOUT_ERR,
  output logic                   ABORT
);

  localparam bit               WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  z3_state_e              state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [NUM_TARGETS-1:0] tgt_nxt;
  logic                   dtack_nxt, berr_nxt, tmo_nxt, abort_nxt;
  logic                   ds_s, doe_s, claim, expire, wd_hit, tgt_ack;

  sync2 u_ds_sync  (.clk(CLK), .rst(RESET), .d(DS_n != 4'hF), .q(ds_s));
  sync2 u_doe_sync (.clk(CLK), .rst(RESET), .d(DOE),          .q(doe_s));

  assign claim   = !FCS_n && ADDR_MATCH && validspace(FC) && (|REGION_SEL);
  assign tgt_ack = |(TGT_DTACK & TGT_CYCLE);
  assign wd_hit  = WD_EN && (cnt == WD_LAST);
  assign BUSY    = (state != Z3_IDLE);
  // Combinational so the card answers within the Zorro slave response window.
  assign SLAVE_n = RESET || !(claim || (BUSY && !FCS_n));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tgt_nxt   = TGT_CYCLE;
    dtack_nxt = DTACK_OE;
    berr_nxt  = BERR_OE;
    tmo_nxt   = 1'b0;
    abort_nxt = 1'b0;
    expire    = 1'b0;

    if ((state == Z3_START) || (state == Z3_DATA))
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    unique case (state)
      Z3_IDLE: begin
        dtack_nxt = 1'b0;
        cnt_nxt   = '0;
        tgt_nxt   = '0;
        if (claim) begin
          state_nxt = Z3_START;
          tgt_nxt   = NUM_TARGETS'(lowest_set(Z3_SEL_MAX'(REGION_SEL)));
        end
      end
      Z3_START: begin
        if (FCS_n) begin
          state_nxt = Z3_IDLE;
          abort_nxt = 1'b1;
          tgt_nxt   = '0;
        end else if (wd_hit) begin
          expire = 1'b1;
        end else if (doe_s && ds_s) begin
          state_nxt = Z3_DATA;
        end
      end
      Z3_DATA: begin
        // Abort beats ack, and ack beats the watchdog in the same cycle.
        if (FCS_n) begin
          state_nxt = Z3_IDLE;
          abort_nxt = 1'b1;
          tgt_nxt   = '0;
        end else if (tgt_ack) begin
          state_nxt = Z3_END;
        end else if (wd_hit) begin
          expire = 1'b1;
        end
      end
      Z3_END: begin
        if (FCS_n) begin
          state_nxt = Z3_IDLE;
          dtack_nxt = 1'b0;
          berr_nxt  = 1'b0;
          tgt_nxt   = '0;
        end else if (!BERR_OE) begin
          dtack_nxt = 1'b1;
        end
      end
      default: state_nxt = Z3_IDLE;
    endcase

    if (expire) begin
      state_nxt = Z3_END;
      tmo_nxt   = 1'b1;
`ifdef Z3_TIMEOUT_BERR_EN
      berr_nxt  = 1'b1;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= Z3_IDLE;
      cnt         <= '0;
      TGT_CYCLE   <= '0;
      DTACK_OE    <= 1'b0;
      BERR_OE     <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      ABORT       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      TGT_CYCLE   <= tgt_nxt;
      DTACK_OE    <= dtack_nxt;
      BERR_OE     <= berr_nxt;
      TIMEOUT_ERR <= tmo_nxt;
      ABORT       <= abort_nxt;
    end
  end

endmodule
